// File: rtl/idma_error_reporter.sv
// Frontend-side iDMA error reporter: consumes 1D responses, captures the first error,
// raises a level irq and answers the backend with continue/abort decisions.
//
// state  | meaning
// IDLE   | accepting responses, counting completions and errors
// DECIDE | error accepted, backend stalled; auto decision offered or waiting for software
// ISSUE  | software decision registered and offered to the backend until accepted

package idma_pkg;
    typedef logic idma_eh_req_t;
    localparam idma_eh_req_t CONTINUE = 1'b0;
    localparam idma_eh_req_t ABORT    = 1'b1;

    typedef enum logic [1:0] {
        BUS_READ  = 2'd0,
        BUS_WRITE = 2'd1,
        BACKEND   = 2'd2,
        ND_MIDEND = 2'd3
    } err_type_t;

    typedef logic [31:0] addr_t;

    typedef struct packed {
        logic [1:0] cause;
        err_type_t  err_type;
        addr_t      burst_addr;
    } err_payload_t;

    typedef struct packed {
        logic         last;
        logic         error;
        err_payload_t pld;
    } idma_rsp_t;
endpackage

module idma_error_reporter #(
    parameter int unsigned CntWidth      = 32,
    parameter type         addr_t        = idma_pkg::addr_t,
    parameter type         idma_rsp_t    = idma_pkg::idma_rsp_t,
    parameter type         idma_eh_req_t = idma_pkg::idma_eh_req_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  idma_rsp_t           rsp_i,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    output idma_eh_req_t        eh_o,
    output logic                eh_valid_o,
    input  logic                eh_ready_i,
    input  logic [1:0]          mode_i,
    input  idma_eh_req_t        sw_eh_i,
    input  logic                sw_eh_valid_i,
    output logic                sw_eh_ready_o,
    input  logic                err_clear_i,
    output logic                err_valid_o,
    output logic [1:0]          err_cause_o,
    output idma_pkg::err_type_t err_type_o,
    output addr_t               err_addr_o,
    output logic                irq_o,
    output logic [CntWidth-1:0] done_cnt_o,
    output logic [CntWidth-1:0] err_cnt_o,
    output logic                busy_o
);

    localparam logic [1:0] ModeAutoContinue = 2'd0;
    localparam logic [1:0] ModeAutoAbort    = 2'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        ISSUE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    idma_eh_req_t        eh_q, eh_d;
    logic                err_valid_q, err_valid_d;
    logic [1:0]          err_cause_q;
    idma_pkg::err_type_t err_type_q;
    addr_t               err_addr_q;
    logic [CntWidth-1:0] done_cnt_q, err_cnt_q;

    logic rsp_acc, err_acc, done_inc, capture_en;

    assign rsp_ready_o = (state_q == IDLE);
    assign rsp_acc     = rsp_valid_i & rsp_ready_o;
    assign err_acc     = rsp_acc & rsp_i.error;
    assign done_inc    = rsp_acc & ~rsp_i.error & rsp_i.last;
    // first error wins: only an empty capture is loaded
    assign capture_en  = err_acc & ~err_valid_q;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        eh_d          = eh_q;
        eh_o          = idma_pkg::CONTINUE;
        eh_valid_o    = 1'b0;
        sw_eh_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (err_acc) begin
                    mode_d  = mode_i;
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
                case (mode_q)
                    ModeAutoContinue: begin
                        eh_valid_o = 1'b1;
                        eh_o       = idma_pkg::CONTINUE;
                        if (eh_ready_i) state_d = IDLE;
                    end
                    ModeAutoAbort: begin
                        eh_valid_o = 1'b1;
                        eh_o       = idma_pkg::ABORT;
                        if (eh_ready_i) state_d = IDLE;
                    end
                    default: begin
                        // reserved mode falls back to a software decision
                        sw_eh_ready_o = 1'b1;
                        if (sw_eh_valid_i) begin
                            eh_d    = sw_eh_i;
                            state_d = ISSUE;
                        end
                    end
                endcase
            end
            ISSUE: begin
                eh_valid_o = 1'b1;
                eh_o       = eh_q;
                if (eh_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_valid_d = err_valid_q;
        if (capture_en) begin
            err_valid_d = 1'b1;
        end else if (err_clear_i) begin
            err_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= ModeAutoContinue;
            eh_q    <= idma_pkg::CONTINUE;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            eh_q    <= eh_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_q <= 1'b0;
            err_cause_q <= 2'd0;
            err_type_q  <= idma_pkg::BUS_READ;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            if (capture_en) begin
                err_cause_q <= rsp_i.pld.cause;
                err_type_q  <= rsp_i.pld.err_type;
                err_addr_q  <= rsp_i.pld.burst_addr;
            end
        end
    end

    // saturating counters, they stick at all-ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (done_inc && (done_cnt_q != '1)) done_cnt_q <= done_cnt_q + CntWidth'(1);
            if (err_acc && (err_cnt_q != '1))   err_cnt_q  <= err_cnt_q + CntWidth'(1);
        end
    end

    assign err_valid_o = err_valid_q;
    assign irq_o       = err_valid_q;
    assign err_cause_o = err_cause_q;
    assign err_type_o  = err_type_q;
    assign err_addr_o  = err_addr_q;
    assign done_cnt_o  = done_cnt_q;
    assign err_cnt_o   = err_cnt_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_idma_error_reporter.sv
// Directed bench for idma_error_reporter: a 32-bit-counter instance for the functional
// scenarios and a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_idma_error_reporter;

    logic                   clk = 1'b0;
    logic                   rst_n;
    idma_pkg::idma_rsp_t    rsp;
    logic                   rsp_valid, rsp_ready;
    idma_pkg::idma_eh_req_t eh, sw_eh;
    logic                   eh_valid, eh_ready;
    logic [1:0]             mode;
    logic                   sw_eh_valid, sw_eh_ready, err_clear, err_valid, irq, busy;
    logic [1:0]             err_cause;
    idma_pkg::err_type_t    err_type;
    logic [31:0]            err_addr, done_cnt, err_cnt;

    logic                   d4_rsp_ready, d4_eh_valid, d4_sw_eh_ready, d4_err_valid, d4_irq, d4_busy;
    idma_pkg::idma_eh_req_t d4_eh;
    logic [1:0]             d4_err_cause;
    idma_pkg::err_type_t    d4_err_type;
    logic [31:0]            d4_err_addr;
    logic [3:0]             d4_done_cnt, d4_err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    idma_error_reporter #(.CntWidth(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rsp_i(rsp), .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready),
        .eh_o(eh), .eh_valid_o(eh_valid), .eh_ready_i(eh_ready),
        .mode_i(mode), .sw_eh_i(sw_eh), .sw_eh_valid_i(sw_eh_valid), .sw_eh_ready_o(sw_eh_ready),
        .err_clear_i(err_clear), .err_valid_o(err_valid), .err_cause_o(err_cause),
        .err_type_o(err_type), .err_addr_o(err_addr), .irq_o(irq),
        .done_cnt_o(done_cnt), .err_cnt_o(err_cnt), .busy_o(busy)
    );

    idma_error_reporter #(.CntWidth(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .rsp_i(rsp), .rsp_valid_i(rsp_valid), .rsp_ready_o(d4_rsp_ready),
        .eh_o(d4_eh), .eh_valid_o(d4_eh_valid), .eh_ready_i(eh_ready),
        .mode_i(mode), .sw_eh_i(sw_eh), .sw_eh_valid_i(sw_eh_valid), .sw_eh_ready_o(d4_sw_eh_ready),
        .err_clear_i(err_clear), .err_valid_o(d4_err_valid), .err_cause_o(d4_err_cause),
        .err_type_o(d4_err_type), .err_addr_o(d4_err_addr), .irq_o(d4_irq),
        .done_cnt_o(d4_done_cnt), .err_cnt_o(d4_err_cnt), .busy_o(d4_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        rsp         = '0;
        rsp_valid   = 1'b0;
        eh_ready    = 1'b0;
        mode        = 2'd0;
        sw_eh       = idma_pkg::CONTINUE;
        sw_eh_valid = 1'b0;
        err_clear   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic drive_err(input logic [31:0] addr, input logic [1:0] cause,
                             input idma_pkg::err_type_t et);
        rsp                = '0;
        rsp.error          = 1'b1;
        rsp.last           = 1'b1;
        rsp.pld.cause      = cause;
        rsp.pld.err_type   = et;
        rsp.pld.burst_addr = addr;
        rsp_valid          = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (rsp_ready !== 1'b1) begin errors++; $display("FAIL reset_rsp_ready got %0b exp 1", rsp_ready); end
        checks++; if (eh !== idma_pkg::CONTINUE || eh_valid !== 1'b0) begin errors++; $display("FAIL reset_eh got eh=%0b valid=%0b exp 0/0", eh, eh_valid); end
        checks++; if ({err_valid, irq, busy, sw_eh_ready} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {err_valid, irq, busy, sw_eh_ready}); end
        checks++; if (done_cnt !== 32'd0 || err_cnt !== 32'd0 || err_addr !== 32'd0) begin errors++; $display("FAIL reset_regs got done=%0d err=%0d addr=%0h exp 0", done_cnt, err_cnt, err_addr); end
    endtask

    task automatic test_auto_continue();
        apply_reset();
        mode     = 2'd0;
        eh_ready = 1'b1;
        drive_err(32'h1000, 2'd2, idma_pkg::BUS_READ);
        step();
        rsp_valid = 1'b0;
        checks++; if (err_valid !== 1'b1 || irq !== 1'b1) begin errors++; $display("FAIL cont_capture got valid=%0b irq=%0b exp 1/1", err_valid, irq); end
        checks++; if (err_addr !== 32'h1000 || err_cause !== 2'd2 || err_type !== idma_pkg::BUS_READ) begin errors++; $display("FAIL cont_payload got addr=%0h cause=%0d type=%0d exp 1000/2/0", err_addr, err_cause, err_type); end
        checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL cont_err_cnt got %0d exp 1", err_cnt); end
        checks++; if (eh_valid !== 1'b1 || eh !== idma_pkg::CONTINUE || rsp_ready !== 1'b0) begin errors++; $display("FAIL cont_decision got valid=%0b eh=%0b rdy=%0b exp 1/0/0", eh_valid, eh, rsp_ready); end
        step();
        checks++; if (busy !== 1'b0 || eh_valid !== 1'b0 || rsp_ready !== 1'b1) begin errors++; $display("FAIL cont_idle got busy=%0b valid=%0b rdy=%0b exp 0/0/1", busy, eh_valid, rsp_ready); end
    endtask

    task automatic test_auto_abort();
        apply_reset();
        mode     = 2'd1;
        eh_ready = 1'b0;
        drive_err(32'h2200, 2'd3, idma_pkg::BUS_WRITE);
        step();
        rsp_valid = 1'b0;
        mode      = 2'd0;
        step();
        checks++; if (eh_valid !== 1'b1 || eh !== idma_pkg::ABORT || sw_eh_ready !== 1'b0) begin errors++; $display("FAIL abort_decision got valid=%0b eh=%0b swrdy=%0b exp 1/1/0", eh_valid, eh, sw_eh_ready); end
        eh_ready = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%0b exp 0", busy); end
    endtask

    task automatic test_software();
        apply_reset();
        mode     = 2'd2;
        eh_ready = 1'b0;
        drive_err(32'h3000, 2'd2, idma_pkg::BACKEND);
        step();
        rsp_valid = 1'b0;
        mode      = 2'd0;
        checks++; if (sw_eh_ready !== 1'b1 || eh_valid !== 1'b0) begin errors++; $display("FAIL sw_wait got swrdy=%0b valid=%0b exp 1/0", sw_eh_ready, eh_valid); end
        step();
        checks++; if (eh_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL sw_mode_held got valid=%0b busy=%0b exp 0/1", eh_valid, busy); end
        sw_eh       = idma_pkg::ABORT;
        sw_eh_valid = 1'b1;
        step();
        sw_eh_valid = 1'b0;
        sw_eh       = idma_pkg::CONTINUE;
        for (int i = 0; i < 3; i++) begin
            checks++; if (eh_valid !== 1'b1 || eh !== idma_pkg::ABORT || rsp_ready !== 1'b0 || sw_eh_ready !== 1'b0) begin errors++; $display("FAIL sw_issue_%0d got valid=%0b eh=%0b rdy=%0b swrdy=%0b exp 1/1/0/0", i, eh_valid, eh, rsp_ready, sw_eh_ready); end
            step();
        end
        eh_ready = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || eh_valid !== 1'b0 || rsp_ready !== 1'b1) begin errors++; $display("FAIL sw_idle got busy=%0b valid=%0b rdy=%0b exp 0/0/1", busy, eh_valid, rsp_ready); end
    endtask

    task automatic test_done_count();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            rsp       = '0;
            rsp.last  = (i % 2 == 0);
            rsp_valid = 1'b1;
            step();
        end
        rsp_valid = 1'b0;
        step();
        checks++; if (done_cnt !== 32'd5 || err_cnt !== 32'd0) begin errors++; $display("FAIL done_count got done=%0d err=%0d exp 5/0", done_cnt, err_cnt); end
        checks++; if (irq !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL done_irq got irq=%0b busy=%0b exp 0/0", irq, busy); end
    endtask

    task automatic test_first_error_wins();
        apply_reset();
        mode     = 2'd0;
        eh_ready = 1'b1;
        drive_err(32'h40, 2'd1, idma_pkg::BUS_READ);
        step();
        rsp_valid = 1'b0;
        step();
        drive_err(32'h80, 2'd3, idma_pkg::BUS_WRITE);
        step();
        rsp_valid = 1'b0;
        step();
        checks++; if (err_addr !== 32'h40 || err_cause !== 2'd1 || err_cnt !== 32'd2) begin errors++; $display("FAIL first_wins got addr=%0h cause=%0d cnt=%0d exp 40/1/2", err_addr, err_cause, err_cnt); end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        checks++; if (err_valid !== 1'b0 || irq !== 1'b0 || err_cnt !== 32'd2) begin errors++; $display("FAIL clear got valid=%0b irq=%0b cnt=%0d exp 0/0/2", err_valid, irq, err_cnt); end
    endtask

    task automatic test_clear_vs_capture();
        apply_reset();
        mode      = 2'd0;
        eh_ready  = 1'b1;
        err_clear = 1'b1;
        drive_err(32'h300, 2'd2, idma_pkg::ND_MIDEND);
        step();
        rsp_valid = 1'b0;
        err_clear = 1'b0;
        checks++; if (err_valid !== 1'b1 || irq !== 1'b1 || err_addr !== 32'h300 || err_type !== idma_pkg::ND_MIDEND) begin errors++; $display("FAIL clear_vs_capture got valid=%0b irq=%0b addr=%0h type=%0d exp 1/1/300/3", err_valid, irq, err_addr, err_type); end
        step();
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            rsp       = '0;
            rsp.last  = 1'b1;
            rsp_valid = 1'b1;
            step();
        end
        rsp_valid = 1'b0;
        step();
        checks++; if (d4_done_cnt !== 4'd15) begin errors++; $display("FAIL sat_done4 got %0d exp 15", d4_done_cnt); end
        checks++; if (done_cnt !== 32'd16) begin errors++; $display("FAIL sat_done32 got %0d exp 16", done_cnt); end
    endtask

    task automatic test_reset_in_decide();
        apply_reset();
        rsp       = '0;
        rsp.last  = 1'b1;
        rsp_valid = 1'b1;
        step();
        mode     = 2'd0;
        eh_ready = 1'b0;
        drive_err(32'h500, 2'd2, idma_pkg::BUS_READ);
        step();
        rsp_valid = 1'b0;
        checks++; if (eh_valid !== 1'b1 || done_cnt !== 32'd1 || err_cnt !== 32'd1) begin errors++; $display("FAIL pre_rst got valid=%0b done=%0d err=%0d exp 1/1/1", eh_valid, done_cnt, err_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (eh_valid !== 1'b0 || busy !== 1'b0 || rsp_ready !== 1'b1) begin errors++; $display("FAIL rst_decide got valid=%0b busy=%0b rdy=%0b exp 0/0/1", eh_valid, busy, rsp_ready); end
        checks++; if (done_cnt !== 32'd0 || err_cnt !== 32'd0 || err_valid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL rst_regs got done=%0d err=%0d valid=%0b irq=%0b exp 0", done_cnt, err_cnt, err_valid, irq); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_auto_continue();
        test_auto_abort();
        test_software();
        test_done_count();
        test_first_error_wins();
        test_clear_vs_capture();
        test_saturation();
        test_reset_in_decide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
